// File: rtl/stopwatch_pkg.sv
// Shared types and BCD limits for the MM:SS stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_ONES_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser plus edge register; rise is a one-cycle pulse two clk edges after
// the input is first sampled high. No backpressure.
module sync_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS BCD stopwatch stepped by slow_clk rising edges; count registers two clk edges after a
// sampled slow_clk rise, no backpressure. STOPWATCH_LAP_HOLD_EN adds a lap freeze of the digit outputs.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_COUNT = 1,
  parameter int MAX_MIN         = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic       lap,
`endif
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover
);

  localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_COUNT - 1);
  localparam bcd_t       MM_TENS    = bcd_t'(MAX_MIN / 10);
  localparam bcd_t       MM_ONES    = bcd_t'(MAX_MIN % 10);

  state_t     state;
  logic [7:0] presc;
  logic       start_stop_q;
  logic       tick;
  logic       cmd;
  bcd_t       so_q, st_q, mo_q, mt_q;
  bcd_t       so_n, st_n, mo_n, mt_n;
  logic       wrap;

  sync_rise_detect u_slow_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (slow_clk),
    .rise     (tick)
  );

  assign cmd = start_stop & ~start_stop_q;

  // Next count value, ripple-carried through all four digits in one cycle.
  always_comb begin
    so_n = so_q + 4'd1;
    st_n = st_q;
    mo_n = mo_q;
    mt_n = mt_q;
    wrap = 1'b0;
    if (so_q == SEC_ONES_MAX) begin
      so_n = 4'd0;
      st_n = st_q + 4'd1;
      if (st_q == SEC_TENS_MAX) begin
        st_n = 4'd0;
        if (mt_q == MM_TENS && mo_q == MM_ONES) begin
          mo_n = 4'd0;
          mt_n = 4'd0;
          wrap = 1'b1;
        end else if (mo_q == SEC_ONES_MAX) begin
          mo_n = 4'd0;
          mt_n = mt_q + 4'd1;
        end else begin
          mo_n = mo_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      running      <= 1'b0;
      rollover     <= 1'b0;
      presc        <= 8'd0;
      start_stop_q <= 1'b0;
      so_q         <= 4'd0;
      st_q         <= 4'd0;
      mo_q         <= 4'd0;
      mt_q         <= 4'd0;
    end else begin
      start_stop_q <= start_stop;
      rollover     <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        running <= 1'b0;
        presc   <= 8'd0;
        so_q    <= 4'd0;
        st_q    <= 4'd0;
        mo_q    <= 4'd0;
        mt_q    <= 4'd0;
      end else if (cmd) begin
        // A tick landing on a control edge is intentionally lost.
        case (state)
          RUN: begin
            state   <= PAUSE;
            running <= 1'b0;
          end
          default: begin
            state   <= RUN;
            running <= 1'b1;
          end
        endcase
      end else if (state == RUN && tick) begin
        if (presc == PRESC_LAST) begin
          presc    <= 8'd0;
          so_q     <= so_n;
          st_q     <= st_n;
          mo_q     <= mo_n;
          mt_q     <= mt_n;
          rollover <= wrap;
        end else begin
          presc <= presc + 8'd1;
        end
      end else if (state == IDLE) begin
        presc <= 8'd0;
      end
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap_q;
  logic hold;
  bcd_t h_so, h_st, h_mo, h_mt;
  logic lap_cmd;

  assign lap_cmd = lap & ~lap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q <= 1'b0;
      hold  <= 1'b0;
      h_so  <= 4'd0;
      h_st  <= 4'd0;
      h_mo  <= 4'd0;
      h_mt  <= 4'd0;
    end else begin
      lap_q <= lap;
      if (clear) begin
        hold <= 1'b0;
      end else if (lap_cmd && state == RUN) begin
        hold <= ~hold;
        if (!hold) begin
          h_so <= so_q;
          h_st <= st_q;
          h_mo <= mo_q;
          h_mt <= mt_q;
        end
      end
    end
  end

  assign sec_ones = hold ? h_so : so_q;
  assign sec_tens = hold ? h_st : st_q;
  assign min_ones = hold ? h_mo : mo_q;
  assign min_tens = hold ? h_mt : mt_q;
`else
  assign sec_ones = so_q;
  assign sec_tens = st_q;
  assign min_ones = mo_q;
  assign min_tens = mt_q;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Three stopwatch instances with different parameters share random stimulus and are
// compared every cycle against an elapsed-seconds model, plus directed timing points.
module tb_stopwatch_bcd_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic slow_clk = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  logic [2:0][3:0] so, st, mo, mt;
  logic [2:0]      run, roll;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stopwatch_bcd_counter #(.TICKS_PER_COUNT(1), .MAX_MIN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]), .min_tens(mt[0]),
    .running(run[0]), .rollover(roll[0]));

  stopwatch_bcd_counter #(.TICKS_PER_COUNT(4), .MAX_MIN(59)) dut_b (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]), .min_tens(mt[1]),
    .running(run[1]), .rollover(roll[1]));

  stopwatch_bcd_counter #(.TICKS_PER_COUNT(1), .MAX_MIN(10)) dut_c (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .sec_ones(so[2]), .sec_tens(st[2]), .min_ones(mo[2]), .min_tens(mt[2]),
    .running(run[2]), .rollover(roll[2]));

  function automatic int tpc_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int mm_of(input int i);
    case (i)
      0:       return 1;
      1:       return 59;
      default: return 10;
    endcase
  endfunction

  function automatic logic [15:0] bcd_of(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: elapsed seconds as a plain integer, mode 0=idle 1=run 2=pause.
  int secs[3], presc[3], mode[3], held[3];
  bit mroll[3], mhold[3];
  bit d1, d2, d3, ss_prev, lap_prev;

  initial begin
    for (int i = 0; i < 3; i++) begin
      secs[i] = 0; presc[i] = 0; mode[i] = 0; held[i] = 0; mroll[i] = 0; mhold[i] = 0;
    end
    d1 = 0; d2 = 0; d3 = 0; ss_prev = 0; lap_prev = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        secs[i] = 0; presc[i] = 0; mode[i] = 0; held[i] = 0; mroll[i] = 0; mhold[i] = 0;
      end
      d1 = 0; d2 = 0; d3 = 0; ss_prev = 0; lap_prev = 0;
    end else begin
      bit tick, cmd, lcmd;
      // A slow_clk rise first sampled at edge N takes effect at edge N+2.
      tick = d2 && !d3;
      cmd  = start_stop && !ss_prev;
      lcmd = lap && !lap_prev;
      for (int i = 0; i < 3; i++) begin
        mroll[i] = 0;
        if (clear) begin
          mode[i] = 0; secs[i] = 0; presc[i] = 0; mhold[i] = 0;
        end else begin
          if (lcmd && mode[i] == 1) begin
            if (mhold[i]) mhold[i] = 0;
            else begin
              mhold[i] = 1;
              held[i] = secs[i];
            end
          end
          if (cmd) begin
            mode[i] = (mode[i] == 1) ? 2 : 1;
          end else if (mode[i] == 1 && tick) begin
            presc[i]++;
            if (presc[i] == tpc_of(i)) begin
              presc[i] = 0;
              secs[i]++;
              if (secs[i] == (mm_of(i) + 1) * 60) begin
                secs[i] = 0;
                mroll[i] = 1;
              end
            end
          end
        end
      end
      d3 = d2; d2 = d1; d1 = slow_clk;
      ss_prev = start_stop;
      lap_prev = lap;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("digits[%0d]", i), {mt[i], mo[i], st[i], so[i]},
          bcd_of(mhold[i] ? held[i] : secs[i]));
      chk($sformatf("running[%0d]", i), 16'(run[i]), 16'(mode[i] == 1));
      chk($sformatf("rollover[%0d]", i), 16'(roll[i]), 16'(mroll[i]));
    end
  end

  // Called at a negedge; returns at a negedge once the tick has registered.
  task automatic tick_pulse(input int hi, input int lo);
    slow_clk = 1'b1;
    repeat (hi) @(negedge clk);
    slow_clk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic start_pulse();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_random(input int cycles, input bit ctrl);
    int rem;
    rem = $urandom_range(2, 5);
    for (int c = 0; c < cycles || slow_clk; c++) begin
      rem--;
      if (rem == 0) begin
        slow_clk = ~slow_clk;
        rem = $urandom_range(2, 5);
      end
      if (ctrl) begin
        if ($urandom_range(0, 99) < 4) start_stop = ~start_stop;
        clear = ($urandom_range(0, 149) == 0);
`ifdef STOPWATCH_LAP_HOLD_EN
        if ($urandom_range(0, 99) < 3) lap = ~lap;
`endif
      end
      @(negedge clk);
    end
    clear = 1'b0;
    lap = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_digits", {mt[0], mo[0], st[0], so[0]}, 16'h0000);
    chk("rst_running", 16'(run[0]), 16'h0);
    chk("rst_rollover", 16'(roll[0]), 16'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Tick latency: slow_clk first sampled high at edge N, count visible after N+2.
    start_pulse();
    slow_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("lat_edge_n1", {mt[0], mo[0], st[0], so[0]}, 16'h0000);
    @(posedge clk);
    #1 chk("lat_edge_n2", {mt[0], mo[0], st[0], so[0]}, 16'h0001);
    chk("lat_running", 16'(run[0]), 16'h1);
    @(negedge clk);
    slow_clk = 1'b0;
    repeat (2) @(negedge clk);

    tick_pulse(20, 2);
    chk("long_high_one_tick", {mt[0], mo[0], st[0], so[0]}, 16'h0002);
    repeat (5) tick_pulse(2, 2);
    chk("run_to_7", {mt[0], mo[0], st[0], so[0]}, 16'h0007);

    // start_stop edge on the same cycle as a tick: pause, tick dropped.
    slow_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start_stop = 1'b1;
    @(negedge clk);
    chk("pause_running", 16'(run[0]), 16'h0);
    chk("pause_digits", {mt[0], mo[0], st[0], so[0]}, 16'h0007);
    slow_clk = 1'b0;
    repeat (2) @(negedge clk);

    // clear wins over a simultaneous start_stop edge.
    start_stop = 1'b0;
    @(negedge clk);
    start_stop = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    chk("clear_running", 16'(run[0]), 16'h0);
    chk("clear_digits", {mt[0], mo[0], st[0], so[0]}, 16'h0000);
    clear = 1'b0;
    start_stop = 1'b0;
    @(negedge clk);

    start_pulse();
    repeat (42) tick_pulse(2, 2);
    chk("count_42", {mt[0], mo[0], st[0], so[0]}, 16'h0042);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_digits", {mt[0], mo[0], st[0], so[0]}, 16'h0000);
    chk("async_running", 16'(run[0]), 16'h0);
    chk("async_digits_c", {mt[2], mo[2], st[2], so[2]}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_pulse();
    run_random(6000, 1'b0);
    run_random(4000, 1'b1);

`ifdef STOPWATCH_LAP_HOLD_EN
    #2 rst_n = 1'b0;
    start_stop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_pulse();
    repeat (10) tick_pulse(2, 2);
    chk("lap_pre", {mt[0], mo[0], st[0], so[0]}, 16'h0010);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    @(negedge clk);
    repeat (5) tick_pulse(2, 2);
    chk("lap_hold", {mt[0], mo[0], st[0], so[0]}, 16'h0010);
    lap = 1'b1;
    @(posedge clk);
    #1 chk("lap_release", {mt[0], mo[0], st[0], so[0]}, 16'h0015);
    @(negedge clk);
    lap = 1'b0;
    repeat (2) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
